// File: rtl/ccip_rd_mux_n.sv
`default_nettype none
// ============================================================================
//  Module   : ccip_rd_mux_n
//  Brief    : N-client CCI-P C0 read-request multiplexer. It arbitrates
//             requests round-robin, tags mdata with the client ID, routes
//             responses back by that tag and keeps a credit count per client.
//             Optional macro CCIP_RD_MUX_RSP_CHECK_EN builds a sticky error
//             flag for stray responses.
//  Revision : 1.0  initial release
// ============================================================================
module ccip_rd_mux_n #(
    parameter int N_CH    = 4,
    parameter int MDATA_W = 16,
    parameter int ADDR_W  = 42,
    parameter int DATA_W  = 512,
    parameter int MAX_OUT = 64,
    localparam int CH_W   = $clog2(N_CH),
    localparam int CMD_W  = MDATA_W - CH_W
) (
    input  logic                    pClk,
    input  logic                    pReset_n,
    input  logic [N_CH-1:0]         cl_req_valid,
    input  logic [N_CH*ADDR_W-1:0]  cl_req_addr,
    input  logic [N_CH*CMD_W-1:0]   cl_req_mdata,
    output logic [N_CH-1:0]         cl_req_ready,
    output logic                    host_req_valid,
    output logic [ADDR_W-1:0]       host_req_addr,
    output logic [MDATA_W-1:0]      host_req_mdata,
    input  logic                    host_almost_full,
    input  logic                    host_rsp_valid,
    input  logic [MDATA_W-1:0]      host_rsp_mdata,
    input  logic [DATA_W-1:0]       host_rsp_data,
    output logic [N_CH-1:0]         cl_rsp_valid,
    output logic [CMD_W-1:0]        cl_rsp_mdata,
    output logic [DATA_W-1:0]       cl_rsp_data,
    output logic                    err_rsp
);

    localparam int               CNT_W   = $clog2(MAX_OUT + 1);
    localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_OUT);
    localparam logic [CH_W:0]    N_CH_X  = (CH_W + 1)'(N_CH);
    localparam logic [CH_W-1:0]  LAST_CH = CH_W'(N_CH - 1);

    logic [N_CH-1:0]    elig;
    logic [N_CH-1:0]    elig_rot;
    logic [N_CH-1:0]    gnt;
    logic [N_CH-1:0]    rsp_hit_vec;
    logic               gnt_found;
    logic [CH_W-1:0]    gnt_off;
    logic [CH_W:0]      gnt_sum;
    logic [CH_W-1:0]    gnt_id;
    logic [ADDR_W-1:0]  sel_addr;
    logic [CMD_W-1:0]   sel_mdata;
    logic [CH_W-1:0]    rsp_id;
    logic               rsp_in_range;

    logic [CH_W-1:0]    ptr_q, ptr_d;
    logic               host_req_valid_q, host_req_valid_d;
    logic [ADDR_W-1:0]  host_req_addr_q, host_req_addr_d;
    logic [MDATA_W-1:0] host_req_mdata_q, host_req_mdata_d;
    logic [N_CH-1:0]    cl_rsp_valid_q, cl_rsp_valid_d;
    logic [CMD_W-1:0]   cl_rsp_mdata_q, cl_rsp_mdata_d;
    logic [DATA_W-1:0]  cl_rsp_data_q, cl_rsp_data_d;

    assign rsp_id       = host_rsp_mdata[MDATA_W-1 -: CH_W];
    assign rsp_in_range = ({1'b0, rsp_id} < N_CH_X);

`ifdef CCIP_RD_MUX_RSP_CHECK_EN
    logic [N_CH-1:0] cnt_zero;
`endif

    for (genvar i = 0; i < N_CH; i++) begin : g_client
        logic [CNT_W-1:0] cnt_q, cnt_d;

        assign elig[i]        = cl_req_valid[i] && (cnt_q < MAX_CNT);
        assign gnt[i]         = gnt_found && (gnt_id == CH_W'(i));
        assign rsp_hit_vec[i] = host_rsp_valid && rsp_in_range && (rsp_id == CH_W'(i));
`ifdef CCIP_RD_MUX_RSP_CHECK_EN
        assign cnt_zero[i]    = (cnt_q == '0);
`endif

        // Simultaneous grant and response cancel; a stray response saturates at 0.
        always_comb begin
            cnt_d = cnt_q;
            if (gnt[i] && !rsp_hit_vec[i]) begin
                cnt_d = cnt_q + CNT_W'(1);
            end else if (!gnt[i] && rsp_hit_vec[i] && (cnt_q != '0)) begin
                cnt_d = cnt_q - CNT_W'(1);
            end
        end

        always_ff @(posedge pClk or negedge pReset_n) begin
            if (!pReset_n) begin
                cnt_q <= '0;
            end else begin
                cnt_q <= cnt_d;
            end
        end
    end

    // Rotate eligibility so bit 0 is the pointer client, pick the lowest set bit.
    always_comb begin
        elig_rot  = N_CH'({elig, elig} >> ptr_q);
        gnt_found = 1'b0;
        gnt_off   = '0;
        for (int k = N_CH - 1; k >= 0; k--) begin
            if (elig_rot[k]) begin
                gnt_found = 1'b1;
                gnt_off   = CH_W'(k);
            end
        end
        if (host_almost_full) begin
            gnt_found = 1'b0;
        end
        gnt_sum = {1'b0, ptr_q} + {1'b0, gnt_off};
        if (gnt_sum >= N_CH_X) begin
            gnt_sum = gnt_sum - N_CH_X;
        end
        gnt_id = gnt_sum[CH_W-1:0];
    end

    always_comb begin
        sel_addr  = '0;
        sel_mdata = '0;
        for (int i = 0; i < N_CH; i++) begin
            if (gnt[i]) begin
                sel_addr  = cl_req_addr[i*ADDR_W +: ADDR_W];
                sel_mdata = cl_req_mdata[i*CMD_W +: CMD_W];
            end
        end
    end

    always_comb begin
        host_req_valid_d = gnt_found;
        host_req_addr_d  = gnt_found ? sel_addr : host_req_addr_q;
        host_req_mdata_d = gnt_found ? {gnt_id, sel_mdata} : host_req_mdata_q;
        ptr_d            = ptr_q;
        if (gnt_found) begin
            ptr_d = (gnt_id == LAST_CH) ? '0 : gnt_id + CH_W'(1);
        end
        cl_rsp_valid_d = rsp_hit_vec;
        cl_rsp_mdata_d = (|rsp_hit_vec) ? host_rsp_mdata[CMD_W-1:0] : cl_rsp_mdata_q;
        cl_rsp_data_d  = (|rsp_hit_vec) ? host_rsp_data : cl_rsp_data_q;
    end

    always_ff @(posedge pClk or negedge pReset_n) begin
        if (!pReset_n) begin
            ptr_q            <= '0;
            host_req_valid_q <= 1'b0;
            host_req_addr_q  <= '0;
            host_req_mdata_q <= '0;
            cl_rsp_valid_q   <= '0;
            cl_rsp_mdata_q   <= '0;
            cl_rsp_data_q    <= '0;
        end else begin
            ptr_q            <= ptr_d;
            host_req_valid_q <= host_req_valid_d;
            host_req_addr_q  <= host_req_addr_d;
            host_req_mdata_q <= host_req_mdata_d;
            cl_rsp_valid_q   <= cl_rsp_valid_d;
            cl_rsp_mdata_q   <= cl_rsp_mdata_d;
            cl_rsp_data_q    <= cl_rsp_data_d;
        end
    end

`ifdef CCIP_RD_MUX_RSP_CHECK_EN
    logic err_q, err_d;

    always_comb begin
        err_d = err_q | (host_rsp_valid && !rsp_in_range) | (|(rsp_hit_vec & cnt_zero));
    end

    always_ff @(posedge pClk or negedge pReset_n) begin
        if (!pReset_n) begin
            err_q <= 1'b0;
        end else begin
            err_q <= err_d;
        end
    end

    assign err_rsp = err_q;
`else
    assign err_rsp = 1'b0;
`endif

    assign cl_req_ready   = gnt;
    assign host_req_valid = host_req_valid_q;
    assign host_req_addr  = host_req_addr_q;
    assign host_req_mdata = host_req_mdata_q;
    assign cl_rsp_valid   = cl_rsp_valid_q;
    assign cl_rsp_mdata   = cl_rsp_mdata_q;
    assign cl_rsp_data    = cl_rsp_data_q;

endmodule
`default_nettype wire

// File: tb/tb_ccip_rd_mux_n.sv
`default_nettype none
// ============================================================================
//  Module   : tb_ccip_rd_mux_n
//  Brief    : Directed bench for ccip_rd_mux_n (4-client and 3-client builds).
//  Revision : 1.0  initial release
// ============================================================================
module tb_ccip_rd_mux_n;

`ifdef CCIP_RD_MUX_RSP_CHECK_EN
    localparam logic ERR_EXP = 1'b1;
`else
    localparam logic ERR_EXP = 1'b0;
`endif

    logic pClk = 1'b0;
    logic pReset_n;
    int   n_pass = 0;
    int   n_tot  = 0;

    always #5 pClk = ~pClk;

    // Four-client instance, two credits per client
    logic [3:0]   a_req_valid;
    logic [167:0] a_req_addr;
    logic [55:0]  a_req_mdata;
    logic [3:0]   a_req_ready;
    logic         a_host_req_valid;
    logic [41:0]  a_host_req_addr;
    logic [15:0]  a_host_req_mdata;
    logic         a_af;
    logic         a_rsp_valid;
    logic [15:0]  a_rsp_mdata;
    logic [63:0]  a_rsp_data;
    logic [3:0]   a_cl_rsp_valid;
    logic [13:0]  a_cl_rsp_mdata;
    logic [63:0]  a_cl_rsp_data;
    logic         a_err;

    // Three-client instance, leaves tag value 3 unused
    logic [2:0]   b_req_valid;
    logic [125:0] b_req_addr;
    logic [41:0]  b_req_mdata;
    logic [2:0]   b_req_ready;
    logic         b_host_req_valid;
    logic [41:0]  b_host_req_addr;
    logic [15:0]  b_host_req_mdata;
    logic         b_rsp_valid;
    logic [15:0]  b_rsp_mdata;
    logic [63:0]  b_rsp_data;
    logic [2:0]   b_cl_rsp_valid;
    logic [13:0]  b_cl_rsp_mdata;
    logic [63:0]  b_cl_rsp_data;
    logic         b_err;

    ccip_rd_mux_n #(.N_CH(4), .MDATA_W(16), .ADDR_W(42), .DATA_W(64), .MAX_OUT(2)) u_dut_a (
        .pClk(pClk), .pReset_n(pReset_n),
        .cl_req_valid(a_req_valid), .cl_req_addr(a_req_addr), .cl_req_mdata(a_req_mdata),
        .cl_req_ready(a_req_ready),
        .host_req_valid(a_host_req_valid), .host_req_addr(a_host_req_addr),
        .host_req_mdata(a_host_req_mdata), .host_almost_full(a_af),
        .host_rsp_valid(a_rsp_valid), .host_rsp_mdata(a_rsp_mdata), .host_rsp_data(a_rsp_data),
        .cl_rsp_valid(a_cl_rsp_valid), .cl_rsp_mdata(a_cl_rsp_mdata), .cl_rsp_data(a_cl_rsp_data),
        .err_rsp(a_err)
    );

    ccip_rd_mux_n #(.N_CH(3), .MDATA_W(16), .ADDR_W(42), .DATA_W(64), .MAX_OUT(2)) u_dut_b (
        .pClk(pClk), .pReset_n(pReset_n),
        .cl_req_valid(b_req_valid), .cl_req_addr(b_req_addr), .cl_req_mdata(b_req_mdata),
        .cl_req_ready(b_req_ready),
        .host_req_valid(b_host_req_valid), .host_req_addr(b_host_req_addr),
        .host_req_mdata(b_host_req_mdata), .host_almost_full(1'b0),
        .host_rsp_valid(b_rsp_valid), .host_rsp_mdata(b_rsp_mdata), .host_rsp_data(b_rsp_data),
        .cl_rsp_valid(b_cl_rsp_valid), .cl_rsp_mdata(b_cl_rsp_mdata), .cl_rsp_data(b_cl_rsp_data),
        .err_rsp(b_err)
    );

    task automatic tick();
        @(posedge pClk);
        #1;
    endtask

    task automatic set_client(input int i, input logic [41:0] addr, input logic [13:0] md);
        a_req_addr[i*42 +: 42]  = addr;
        a_req_mdata[i*14 +: 14] = md;
    endtask

    task automatic rsp_a(input logic [1:0] id, input logic [13:0] md, input logic [63:0] d);
        a_rsp_valid = 1'b1;
        a_rsp_mdata = {id, md};
        a_rsp_data  = d;
    endtask

    task automatic test_reset();
        pReset_n    = 1'b0;
        a_req_valid = '0; a_req_addr = '0; a_req_mdata = '0; a_af = 1'b0;
        a_rsp_valid = 1'b0; a_rsp_mdata = '0; a_rsp_data = '0;
        b_req_valid = '0; b_req_addr = '0; b_req_mdata = '0;
        b_rsp_valid = 1'b0; b_rsp_mdata = '0; b_rsp_data = '0;
        tick(); tick();
        n_tot++;
        if (a_host_req_valid !== 1'b0 || a_host_req_addr !== 42'h0 || a_host_req_mdata !== 16'h0) begin
            $display("FAIL reset_req: got v=%b a=%h m=%h expected zeros", a_host_req_valid, a_host_req_addr, a_host_req_mdata);
        end else n_pass++;
        n_tot++;
        if (a_cl_rsp_valid !== 4'h0 || a_cl_rsp_mdata !== 14'h0 || a_cl_rsp_data !== 64'h0) begin
            $display("FAIL reset_rsp: got v=%b m=%h d=%h expected zeros", a_cl_rsp_valid, a_cl_rsp_mdata, a_cl_rsp_data);
        end else n_pass++;
        n_tot++;
        if (a_err !== 1'b0 || b_err !== 1'b0) begin
            $display("FAIL reset_err: got %b/%b expected 0/0", a_err, b_err);
        end else n_pass++;
        n_tot++;
        if (a_req_ready !== 4'h0) begin
            $display("FAIL reset_ready: got %b expected 0000", a_req_ready);
        end else n_pass++;
        pReset_n = 1'b1;
        tick();
    endtask

    task automatic test_round_robin();
        logic [3:0] exp_rdy;
        logic [1:0] cid;
        for (int i = 0; i < 4; i++) set_client(i, 42'h100 + 42'(i), 14'h10 + 14'(i));
        a_req_valid = 4'hF;
        for (int c = 0; c < 8; c++) begin
            cid     = 2'(c % 4);
            exp_rdy = 4'b0001 << cid;
            #1;
            n_tot++;
            if (a_req_ready !== exp_rdy) begin
                $display("FAIL rr_ready[%0d]: got %b expected %b", c, a_req_ready, exp_rdy);
            end else n_pass++;
            tick();
            n_tot++;
            if (a_host_req_valid !== 1'b1 || a_host_req_mdata !== {cid, 14'h10 + 14'(cid)} ||
                a_host_req_addr !== 42'h100 + 42'(cid)) begin
                $display("FAIL rr_req[%0d]: got v=%b m=%h a=%h expected v=1 m=%h a=%h", c, a_host_req_valid,
                         a_host_req_mdata, a_host_req_addr, {cid, 14'h10 + 14'(cid)}, 42'h100 + 42'(cid));
            end else n_pass++;
        end
        #1;
        n_tot++;
        if (a_req_ready !== 4'h0) begin
            $display("FAIL rr_all_full: got %b expected 0000", a_req_ready);
        end else n_pass++;
        a_req_valid = 4'h0;
        tick();
        n_tot++;
        if (a_host_req_valid !== 1'b0) begin
            $display("FAIL rr_idle: got %b expected 0", a_host_req_valid);
        end else n_pass++;
    endtask

    task automatic test_drain();
        logic [1:0] id;
        for (int r = 0; r < 8; r++) begin
            id = 2'(r % 4);
            rsp_a(id, 14'h1230 + 14'(r), 64'hA0 + 64'(r));
            tick();
            n_tot++;
            if (a_cl_rsp_valid !== (4'b0001 << id) || a_cl_rsp_mdata !== 14'h1230 + 14'(r) ||
                a_cl_rsp_data !== 64'hA0 + 64'(r)) begin
                $display("FAIL drain[%0d]: got v=%b m=%h d=%h expected v=%b m=%h d=%h", r, a_cl_rsp_valid,
                         a_cl_rsp_mdata, a_cl_rsp_data, 4'b0001 << id, 14'h1230 + 14'(r), 64'hA0 + 64'(r));
            end else n_pass++;
        end
        a_rsp_valid = 1'b0;
        tick();
        n_tot++;
        if (a_cl_rsp_valid !== 4'h0) begin
            $display("FAIL drain_idle: got %b expected 0000", a_cl_rsp_valid);
        end else n_pass++;
    endtask

    task automatic test_tag_route();
        set_client(2, 42'h2A, 14'h0ABC);
        a_req_valid = 4'b0100;
        #1;
        n_tot++;
        if (a_req_ready !== 4'b0100) begin
            $display("FAIL tag_ready: got %b expected 0100", a_req_ready);
        end else n_pass++;
        tick();
        n_tot++;
        if (a_host_req_mdata !== 16'h8ABC || a_host_req_addr !== 42'h2A) begin
            $display("FAIL tag_mdata: got m=%h a=%h expected m=8abc a=2a", a_host_req_mdata, a_host_req_addr);
        end else n_pass++;
        a_req_valid = 4'h0;
        a_rsp_valid = 1'b1; a_rsp_mdata = 16'h8ABC; a_rsp_data = 64'hDEAD_BEEF_0123_4567;
        tick();
        a_rsp_valid = 1'b0;
        n_tot++;
        if (a_cl_rsp_valid !== 4'b0100 || a_cl_rsp_mdata !== 14'h0ABC || a_cl_rsp_data !== 64'hDEAD_BEEF_0123_4567) begin
            $display("FAIL tag_route: got v=%b m=%h d=%h expected v=0100 m=0abc d=deadbeef01234567",
                     a_cl_rsp_valid, a_cl_rsp_mdata, a_cl_rsp_data);
        end else n_pass++;
    endtask

    task automatic test_credit();
        set_client(1, 42'h11, 14'h0111);
        a_req_valid = 4'b0010;
        for (int c = 0; c < 2; c++) begin
            #1;
            n_tot++;
            if (a_req_ready !== 4'b0010) begin
                $display("FAIL credit_grant[%0d]: got %b expected 0010", c, a_req_ready);
            end else n_pass++;
            tick();
        end
        #1;
        n_tot++;
        if (a_req_ready !== 4'b0000) begin
            $display("FAIL credit_block: got %b expected 0000", a_req_ready);
        end else n_pass++;
        tick();
        rsp_a(2'd1, 14'h0111, 64'h1);
        #1;
        n_tot++;
        if (a_req_ready !== 4'b0000 || a_host_req_valid !== 1'b0) begin
            $display("FAIL credit_same_cycle: got rdy=%b v=%b expected 0000/0", a_req_ready, a_host_req_valid);
        end else n_pass++;
        tick();
        a_rsp_valid = 1'b0;
        #1;
        n_tot++;
        if (a_req_ready !== 4'b0010) begin
            $display("FAIL credit_regrant: got %b expected 0010", a_req_ready);
        end else n_pass++;
        tick();
        a_req_valid = 4'h0;
        rsp_a(2'd1, 14'h0111, 64'h2); tick();
        rsp_a(2'd1, 14'h0111, 64'h3); tick();
        a_rsp_valid = 1'b0;
    endtask

    task automatic test_almost_full();
        a_req_valid = 4'hF;
        a_af        = 1'b1;
        for (int c = 0; c < 5; c++) begin
            #1;
            n_tot++;
            if (a_req_ready !== 4'h0) begin
                $display("FAIL af_block[%0d]: got %b expected 0000", c, a_req_ready);
            end else n_pass++;
            tick();
        end
        a_af = 1'b0;
        #1;
        n_tot++;
        if (a_req_ready !== 4'b0100 || a_host_req_valid !== 1'b0) begin
            $display("FAIL af_resume: got rdy=%b v=%b expected 0100/0", a_req_ready, a_host_req_valid);
        end else n_pass++;
        tick();
        #1;
        n_tot++;
        if (a_req_ready !== 4'b1000 || a_host_req_mdata[15:14] !== 2'd2) begin
            $display("FAIL af_next: got rdy=%b id=%0d expected 1000/2", a_req_ready, a_host_req_mdata[15:14]);
        end else n_pass++;
        tick();
        a_req_valid = 4'h0;
        rsp_a(2'd2, 14'h0, 64'h0); tick();
        rsp_a(2'd3, 14'h0, 64'h0); tick();
        a_rsp_valid = 1'b0;
    endtask

    task automatic test_same_cycle();
        a_req_valid = 4'b0001;
        tick();
        rsp_a(2'd0, 14'h0055, 64'h55);
        #1;
        n_tot++;
        if (a_req_ready !== 4'b0001) begin
            $display("FAIL same_grant: got %b expected 0001", a_req_ready);
        end else n_pass++;
        tick();
        a_rsp_valid = 1'b0;
        #1;
        n_tot++;
        if (a_cl_rsp_valid !== 4'b0001 || a_req_ready !== 4'b0001) begin
            $display("FAIL same_count_one: got rsp=%b rdy=%b expected 0001/0001", a_cl_rsp_valid, a_req_ready);
        end else n_pass++;
        tick();
        #1;
        n_tot++;
        if (a_req_ready !== 4'b0000) begin
            $display("FAIL same_count_full: got %b expected 0000", a_req_ready);
        end else n_pass++;
        a_req_valid = 4'h0;
        tick();
        rsp_a(2'd0, 14'h0, 64'h0); tick();
        rsp_a(2'd0, 14'h0, 64'h0); tick();
        a_rsp_valid = 1'b0;
    endtask

    task automatic test_reset_mid();
        a_req_valid = 4'b1000;
        tick(); tick();
        a_req_valid = 4'h0;
        pReset_n    = 1'b0;
        #1;
        n_tot++;
        if (a_host_req_valid !== 1'b0 || a_host_req_mdata !== 16'h0) begin
            $display("FAIL mid_reset_async: got v=%b m=%h expected 0/0000", a_host_req_valid, a_host_req_mdata);
        end else n_pass++;
        tick();
        pReset_n = 1'b1;
        tick();
        rsp_a(2'd3, 14'h0033, 64'h33);
        tick();
        n_tot++;
        if (a_cl_rsp_valid !== 4'b1000 || a_cl_rsp_mdata !== 14'h0033) begin
            $display("FAIL inflight_routed: got v=%b m=%h expected 1000/0033", a_cl_rsp_valid, a_cl_rsp_mdata);
        end else n_pass++;
        tick();
        a_rsp_valid = 1'b0;
        n_tot++;
        if (a_err !== ERR_EXP) begin
            $display("FAIL zero_count_err: got %b expected %b", a_err, ERR_EXP);
        end else n_pass++;
        a_req_valid = 4'b1000;
        for (int c = 0; c < 2; c++) begin
            #1;
            n_tot++;
            if (a_req_ready !== 4'b1000) begin
                $display("FAIL sat_grant[%0d]: got %b expected 1000", c, a_req_ready);
            end else n_pass++;
            tick();
        end
        #1;
        n_tot++;
        if (a_req_ready !== 4'b0000) begin
            $display("FAIL sat_full: got %b expected 0000", a_req_ready);
        end else n_pass++;
        a_req_valid = 4'h0;
        tick();
    endtask

    task automatic test_dut_b();
        logic [2:0] exp_rdy;
        b_req_valid = 3'b111;
        for (int c = 0; c < 4; c++) begin
            exp_rdy = 3'b001 << (c % 3);
            #1;
            n_tot++;
            if (b_req_ready !== exp_rdy) begin
                $display("FAIL b_rr[%0d]: got %b expected %b", c, b_req_ready, exp_rdy);
            end else n_pass++;
            tick();
        end
        b_req_valid = 3'b000;
        n_tot++;
        if (b_host_req_mdata[15:14] !== 2'd0) begin
            $display("FAIL b_wrap_tag: got %0d expected 0", b_host_req_mdata[15:14]);
        end else n_pass++;
        b_rsp_valid = 1'b1; b_rsp_mdata = 16'hC123; b_rsp_data = 64'h77;
        tick();
        b_rsp_valid = 1'b0;
        n_tot++;
        if (b_cl_rsp_valid !== 3'b000 || b_err !== ERR_EXP) begin
            $display("FAIL b_bad_id: got v=%b err=%b expected 000/%b", b_cl_rsp_valid, b_err, ERR_EXP);
        end else n_pass++;
        tick(); tick();
        n_tot++;
        if (b_err !== ERR_EXP) begin
            $display("FAIL b_err_sticky: got %b expected %b", b_err, ERR_EXP);
        end else n_pass++;
        pReset_n = 1'b0;
        tick();
        n_tot++;
        if (b_err !== 1'b0) begin
            $display("FAIL b_err_clear: got %b expected 0", b_err);
        end else n_pass++;
        pReset_n = 1'b1;
        tick();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        test_reset();
        test_round_robin();
        test_drain();
        test_tag_route();
        test_credit();
        test_almost_full();
        test_same_cycle();
        test_reset_mid();
        test_dut_b();
        $display("%0d/%0d checks passed", n_pass, n_tot);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/ccip_rd_mux_n.md
# ccip_rd_mux_n

Parametrised N-client read-request multiplexer for the CCI-P C0 channel, sitting between the AFU top level and the host interface (after the clock-crossing shim when one is built in). It arbitrates client read requests round-robin and tags each request's mdata with the client ID. It routes read responses back by that tag and bounds each client's outstanding reads with a per-client credit counter. It replaces the fixed single-client wiring so that several engines can share one host read port.

## Interface
Parameters:
- N_CH, 4, number of clients (2..16); CH_W = $clog2(N_CH), derived, not overridable
- MDATA_W, 16, host mdata width; client mdata width is MDATA_W-CH_W
- ADDR_W, 42, cache-line address width
- DATA_W, 512, response data width
- MAX_OUT, 64, maximum outstanding reads per client (counter width $clog2(MAX_OUT+1))

Ports:
- pClk  in  1  system clock; everything is sampled on its rising edge
- pReset_n  in  1  asynchronous active-low reset
- cl_req_valid  in  N_CH  per-client request valid
- cl_req_addr  in  N_CH*ADDR_W  per-client address, client i in slice i
- cl_req_mdata  in  N_CH*(MDATA_W-CH_W)  per-client mdata
- cl_req_ready  out  N_CH  one-hot grant; a request is accepted when valid&ready
- host_req_valid  out  1  registered request to the host
- host_req_addr  out  ADDR_W  registered address
- host_req_mdata  out  MDATA_W  {client_id, client mdata}
- host_almost_full  in  1  C0 TX almost-full from the host
- host_rsp_valid  in  1  C0 RX read response valid
- host_rsp_mdata  in  MDATA_W  response mdata
- host_rsp_data  in  DATA_W  response data
- cl_rsp_valid  out  N_CH  one-hot registered response valid
- cl_rsp_mdata  out  MDATA_W-CH_W  shared response mdata, tag bits stripped
- cl_rsp_data  out  DATA_W  shared response data
- err_rsp  out  1  sticky protocol-error flag (see Configuration)

## Operation
- Eligible client: cl_req_valid[i]=1 and outstanding[i]<MAX_OUT.
- Grant: when host_almost_full=0, cl_req_ready asserts for exactly one eligible client. The grant is combinational from valid, almost-full, the counters and the pointer.
- Round-robin: the pointer names the highest-priority client. After a grant to client i, the pointer becomes (i+1) mod N_CH. With no grant, the pointer holds.
- Request tagging: host_req_mdata = {i[CH_W-1:0], cl_req_mdata slice i}.
- Response routing: id = host_rsp_mdata[MDATA_W-1 -: CH_W].
  - id<N_CH: cl_rsp_valid[id] is set and the low mdata bits and the data are forwarded.
  - id>=N_CH (possible only when N_CH is not a power of 2): the response is dropped and no counter changes.
- Counters: outstanding[i] increments on a grant to i and decrements on a response routed to i.
  - A grant and a response to the same client in the same cycle leave the counter unchanged.
  - A decrement at 0 saturates at 0.
- Reset mid-operation: all state clears immediately. In-flight responses arriving after reset are routed but do not decrement below 0.

## Timing
- Reset values: host_req_valid=0, host_req_addr=0, host_req_mdata=0, cl_rsp_valid=0, cl_rsp_mdata=0, cl_rsp_data=0, err_rsp=0. The pointer, all counters and the request/response registers are also 0. cl_req_ready=0 whenever all cl_req_valid=0.
- Request latency: a grant in cycle t gives host_req_valid=1 in cycle t+1. With continuous grants there is one request per cycle.
- Response latency: host_rsp_valid in cycle t gives cl_rsp_valid in cycle t+1.
- host_almost_full blocks grants in the same cycle it is high. A request already registered still issues in the next cycle; the host's almost-full slack covers it.
- A counter update is visible to eligibility in the cycle after the grant or response.

## Configuration
- CCIP_RD_MUX_RSP_CHECK_EN defined:
  - err_rsp sets and stays set until reset on either of two events: a response with id>=N_CH, or a response to a client whose outstanding count is 0.
  - Routing behaviour is unchanged.
- Undefined: err_rsp is tied to 0 and no check logic is built.

## Test plan
- N_CH=4, all four clients hold valid for 8 cycles, pointer=0 → grants 0,1,2,3,0,1,2,3; host_req_mdata[15:14] follows the same sequence; one request per cycle.
- Client 2 alone, mdata=0x0ABC → host_req_mdata=0x8ABC one cycle after the grant. Response mdata=0x8ABC → cl_rsp_valid=4'b0100 and cl_rsp_mdata=0x0ABC one cycle later.
- MAX_OUT=2, client 1 issues 2 requests with no responses → cl_req_ready[1]=0 on the third attempt. After one response to client 1, the next cycle grants it again.
- host_almost_full=1 for 5 cycles with all valid → cl_req_ready=0 throughout. The pointer holds, and arbitration resumes at the held pointer.
- Grant and response to client 0 in the same cycle with outstanding[0]=1 → the count stays 1.
- N_CH=3, CHECK_EN defined, response with id=3 → no cl_rsp_valid and err_rsp=1 until pReset_n=0. With the macro undefined, err_rsp stays 0.
